xor_switch_regfile: RTL



---
 rtl/xor_switch_regfile_if.sv | 27 ++
 rtl/xor_switch_regfile.sv | 74 +++++++
 2 files changed

// File: rtl/xor_switch_regfile_if.sv
// Write/read bus of the XOR/switch register file.
interface xor_switch_regfile_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic              wr_en;
  logic [1:0]        wr_mode;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              sw_en;
  logic [WIDTH-1:0]  rd_data;
  logic              rd_valid;

  modport master (
    output wr_en, wr_mode, wr_addr, wr_data, rd_en, rd_addr, sw_en,
    input  rd_data, rd_valid
  );

  modport slave (
    input  wr_en, wr_mode, wr_addr, wr_data, rd_en, rd_addr, sw_en,
    output rd_data, rd_valid
  );
endinterface

// File: rtl/xor_switch_regfile.sv
// Bank of DEPTH words with load/XOR/clear/invert writes and a registered,
// output-switched read port with write-through forwarding.
module xor_switch_regfile #(
  parameter  int unsigned WIDTH  = 8,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input logic                 clk,
  input logic                 rst_n,
  xor_switch_regfile_if.slave bus
);
  typedef enum logic [1:0] {
    MODE_LOAD   = 2'b00,
    MODE_XOR    = 2'b01,
    MODE_CLEAR  = 2'b10,
    MODE_INVERT = 2'b11
  } wr_mode_e;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  wr_mode_e         mode;
  logic             wr_ok;
  logic             rd_ok;
  logic [WIDTH-1:0] wr_cur;
  logic [WIDTH-1:0] wr_new;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  always_comb begin
    mode   = wr_mode_e'(bus.wr_mode);
    wr_ok  = bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_C);
    rd_ok  = {1'b0, bus.rd_addr} < DEPTH_C;
    wr_cur = '0;
    if (wr_ok) wr_cur = mem_q[bus.wr_addr];

    wr_new = wr_cur;
    case (mode)
      MODE_LOAD:   wr_new = bus.wr_data;
      MODE_XOR:    wr_new = wr_cur ^ bus.wr_data;
      MODE_CLEAR:  wr_new = '0;
      MODE_INVERT: wr_new = ~wr_cur;
      default:     wr_new = wr_cur;
    endcase

    mem_d = mem_q;
    if (wr_ok) mem_d[bus.wr_addr] = wr_new;

    // Reading from mem_d gives same-address write-through for free.
    rd_word = '0;
    if (rd_ok) rd_word = mem_d[bus.rd_addr];

    rd_valid_d = bus.rd_en;
    rd_data_d  = rd_data_q;
    if (bus.rd_en) rd_data_d = bus.sw_en ? rd_word : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
endmodule
